// File: rtl/osc_cmp_arb.sv
// Round-robin arbiter that multiplexes oscillation-channel compare requests onto one
// shared float subtract+compare pipeline, with a per-operation response timeout.
module osc_cmp_arb #(
  parameter int CH_NUM  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic [CH_NUM-1:0]      i_req,
  input  logic [32*CH_NUM-1:0]   i_max_data,
  input  logic [32*CH_NUM-1:0]   i_min_data,
  input  logic [32*CH_NUM-1:0]   i_thresh,
  output logic [31:0]            o_fp_a,
  output logic [31:0]            o_fp_b,
  output logic [31:0]            o_fp_thresh,
  output logic                   o_fp_valid,
  input  logic                   i_fp_result,
  input  logic                   i_fp_valid,
  output logic [CH_NUM-1:0]      o_ack,
  output logic                   o_result,
  output logic [CH_NUM-1:0]      o_timeout_err,
  output logic                   o_busy,
  output logic [1:0]             o_state
);

  localparam int         GW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [31:0]       op_t_q, op_t_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              result_q, result_d;
  logic [CH_NUM-1:0] err_q, err_d;

  logic [GW-1:0]     arb_idx, hi_idx, lo_idx;
  logic              hi_found;
  logic [CH_NUM-1:0] grant_oh;
  logic              wait_hit, wait_tmo;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = CH_NUM - 1; c >= 0; c--) begin
      if (i_req[c]) begin
        lo_idx = GW'(c);
        if (c >= int'(rr_ptr_q)) begin
          hi_idx   = GW'(c);
          hi_found = 1'b1;
        end
      end
    end
    arb_idx = hi_found ? hi_idx : lo_idx;
  end

  assign grant_oh = {{(CH_NUM-1){1'b0}}, 1'b1} << grant_q;
  assign wait_hit = (state_q == ST_WAIT) && i_fp_valid;
  // A response arriving on the last allowed cycle beats the timeout.
  assign wait_tmo = (state_q == ST_WAIT) && !i_fp_valid && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_t_q   <= '0;
      cnt_q    <= '0;
      result_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_t_q   <= op_t_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|i_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (wait_hit || wait_tmo) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_t_d   = op_t_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = i_clr ? '0 : err_q;
    if (wait_tmo) err_d = err_d | grant_oh;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          grant_d = arb_idx;
          op_a_d  = i_max_data[32*arb_idx +: 32];
          op_b_d  = i_min_data[32*arb_idx +: 32];
          op_t_d  = i_thresh[32*arb_idx +: 32];
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (wait_hit)      result_d = i_fp_result;
        else if (wait_tmo) result_d = 1'b0;
      end
      ST_DONE: rr_ptr_d = (grant_q == GW'(CH_NUM - 1)) ? '0 : grant_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_fp_valid = (state_q == ST_ISSUE);
    o_ack      = (state_q == ST_DONE) ? grant_oh : '0;
    o_result   = (state_q == ST_DONE) && result_q;
    o_busy     = (state_q != ST_IDLE);
    o_state    = state_q;
  end

  assign o_fp_a        = op_a_q;
  assign o_fp_b        = op_b_q;
  assign o_fp_thresh   = op_t_q;
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_osc_cmp_arb.sv
// Randomized bench for osc_cmp_arb: acts as the shared float pipeline and checks
// grants, operands, latency, results and timeout flags against a transaction model.
module tb_osc_cmp_arb;

  localparam int CH = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst, clr, fp_res, fp_vin;
  logic [CH-1:0]     req;
  logic [32*CH-1:0]  maxd, mind, thd;
  logic [31:0]       o_fp_a, o_fp_b, o_fp_thresh;
  logic              o_fp_valid, o_result, o_busy;
  logic [CH-1:0]     o_ack, o_timeout_err;
  logic [1:0]        o_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] max_v [CH];
  logic [31:0] min_v [CH];
  logic [31:0] th_v  [CH];
  int          rr_m;
  logic [CH-1:0] err_m;

  always #5 clk = ~clk;

  osc_cmp_arb #(.CH_NUM(CH), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_req(req),
    .i_max_data(maxd), .i_min_data(mind), .i_thresh(thd),
    .o_fp_a(o_fp_a), .o_fp_b(o_fp_b), .o_fp_thresh(o_fp_thresh), .o_fp_valid(o_fp_valid),
    .i_fp_result(fp_res), .i_fp_valid(fp_vin),
    .o_ack(o_ack), .o_result(o_result), .o_timeout_err(o_timeout_err),
    .o_busy(o_busy), .o_state(o_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < CH; i++) begin
      maxd[32*i +: 32] = max_v[i];
      mind[32*i +: 32] = min_v[i];
      thd[32*i +: 32]  = th_v[i];
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH; i++) begin
      max_v[i] = $urandom;
      min_v[i] = $urandom;
      th_v[i]  = $urandom;
    end
    pack();
  endtask

  // Spec rule: first requesting channel at or above the pointer, modulo CH.
  function automatic int pick(input logic [CH-1:0] r, input int p);
    for (int o = 0; o < CH; o++)
      if (r[(p + o) % CH]) return (p + o) % CH;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_m  = 0;
    err_m = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    err_m = '0;
    chk("clr_err", 32'(o_timeout_err), 32'(err_m));
  endtask

  // One transaction: k = response latency after issue (k > TO means no response).
  task automatic run_op(input int k, input bit res, input bit scramble, input bit drop,
                        input bit clr_race, input bit stale, input logic [CH-1:0] next_req,
                        input int exp_wait);
    int g, waited, lat;
    bit tmo;
    logic [31:0] ea, eb, et;
    g  = pick(req, rr_m);
    ea = max_v[g];
    eb = min_v[g];
    et = th_v[g];
    waited = 0;
    while (o_fp_valid !== 1'b1 && waited < 8) begin
      step();
      fp_vin = 1'b0;
      waited++;
    end
    chk("issue_seen", 32'(o_fp_valid), 32'd1);
    if (o_fp_valid !== 1'b1) return;
    if (exp_wait >= 0) chk("issue_lat", 32'(waited), 32'(exp_wait));
    chk("issue_a", o_fp_a, ea);
    chk("issue_b", o_fp_b, eb);
    chk("issue_t", o_fp_thresh, et);
    chk("issue_busy", 32'(o_busy), 32'd1);
    if (stale && k >= 2) begin
      fp_vin = 1'b1;
      fp_res = ~res;
    end
    if (scramble) begin
      max_v[g] = ~ea;
      min_v[g] = $urandom;
      pack();
    end
    if (drop) req = '0;
    tmo = (k > TO);
    lat = tmo ? TO : k;
    for (int j = 1; j <= lat; j++) begin
      step();
      fp_vin = 1'b0;
      clr    = 1'b0;
      chk("wait_state", 32'(o_state), 32'd2);
      chk("wait_ack", 32'(o_ack), 32'd0);
      chk("wait_hold_a", o_fp_a, ea);
      if (j == k) begin
        fp_vin = 1'b1;
        fp_res = res;
      end
      if (clr_race && tmo && j == TO) clr = 1'b1;
    end
    step();
    fp_vin = 1'b0;
    clr    = 1'b0;
    if (tmo) err_m = (clr_race ? '0 : err_m) | CH'(1 << g);
    chk("ack", 32'(o_ack), 32'(1 << g));
    chk("result", 32'(o_result), tmo ? 32'd0 : 32'(res));
    chk("err", 32'(o_timeout_err), 32'(err_m));
    chk("done_b", o_fp_b, eb);
    chk("done_t", o_fp_thresh, et);
    $display("op ch=%0d k=%0d res=%0d ack=%b result=%0d err=%b", g, k, res, o_ack, o_result,
             o_timeout_err);
    rr_m = (g + 1) % CH;
    if (stale) begin
      fp_vin = 1'b1;
      fp_res = 1'b1;
    end
    req = next_req;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; fp_vin = 1'b0; fp_res = 1'b0;
    rand_data();
    step();
    step();
    rst = 1'b0;
    rr_m = 0;
    err_m = '0;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_fpv", 32'(o_fp_valid), 32'd0);
    chk("rst_res", 32'(o_result), 32'd0);
    chk("rst_fpa", o_fp_a, 32'd0);
    chk("rst_err", 32'(o_timeout_err), 32'd0);

    // Single request, response two cycles after issue.
    req = 4'b0001;
    run_op(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1);
    step();
    fp_vin = 1'b0;

    // Contention with every channel held high.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++)
      run_op($urandom_range(1, 5), 1'(i), 1'b0, 1'b0, 1'b0, 1'b0,
             (i == 4) ? 4'b0000 : 4'b1111, -1);
    step();

    // Timeout then clear; then response on the timeout cycle.
    req = 4'b0100;
    run_op(TO + 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    do_clr();
    req = 4'b0100;
    run_op(TO + 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    step();
    req = 4'b0100;
    run_op(TO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    do_clr();

    // Operand stability while data changes during WAIT.
    req = 4'b0010;
    run_op(6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, -1);
    step();

    // Reset mid-WAIT followed by a late pipeline response.
    req = 4'b0010;
    for (int w = 0; w < 8 && o_fp_valid !== 1'b1; w++) step();
    step();
    step();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    rr_m = 0;
    err_m = '0;
    chk("mrst_state", 32'(o_state), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_fpa", o_fp_a, 32'd0);
    fp_vin = 1'b1;
    fp_res = 1'b1;
    step();
    fp_vin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mrst_ack", 32'(o_ack), 32'd0);
      chk("mrst_idle", 32'(o_state), 32'd0);
      chk("mrst_res", 32'(o_result), 32'd0);
      step();
    end

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if (req == '0) begin
        if ($urandom_range(0, 3) == 0) do_clr();
        rand_data();
        req = CH'($urandom_range(1, (1 << CH) - 1));
      end
      run_op($urandom_range(1, TO + 3), 1'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0) ? '0 : CH'($urandom_range(1, (1 << CH) - 1)), -1);
    end
    step();
    fp_vin = 1'b0;
    req = '0;
    step();
    step();
    chk("final_idle", 32'(o_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
